lsu_mem_initiator: RTL and testbench

- Requester-side engine for the data-memory port: converts one CPU load/store request into a single memory access on the data_mem interface.
- Follows the memory's busy/stall indication and returns load data to the pipeline, extracted and extended to 32 bits.
- Sits between the cpu core and data_mem on the processor clock domain.
- Replaces clock-gating stall handling with an explicit ready/valid handshake.

---
 rtl/lsu_pkg.sv | 64 ++++++
 rtl/lsu_load_align.sv | 43 ++++
 rtl/lsu_mem_initiator.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU data-memory initiator.
// The FSM state encoding, the RISC-V funct3 codes, the size field of
// mem_sign_mask and the request-decoding helpers are defined here.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // One-hot access size carried in mem_sign_mask[2:0]
    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b100;

    // Bit 3 marks a sign-extending load; stores never set it.
    function automatic logic [3:0] funct3_to_sign_mask(input logic [2:0] funct3,
                                                       input logic       is_write);
        logic [2:0] size;
        logic       sgn;
        case (funct3[1:0])
            2'b00:   size = SZ_BYTE;
            2'b01:   size = SZ_HALF;
            2'b10:   size = SZ_WORD;
            default: size = 3'b000;
        endcase
        sgn = ~is_write & ~funct3[2];
        return {sgn, size};
    endfunction

    // Loads accept all five codes; stores accept only the signed-looking ones.
    function automatic logic funct3_is_legal(input logic [2:0] funct3,
                                             input logic       is_write);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halves need an even address, words a 4-byte aligned address.
    function automatic logic funct3_is_misaligned(input logic [2:0] funct3,
                                                  input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane extraction: picks the addressed byte or half out of the
// aligned memory word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the byte and half lanes addressed by the low address bits
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_s = word_i[7:0];
            2'b01:   byte_s = word_i[15:8];
            2'b10:   byte_s = word_i[23:16];
            2'b11:   byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
    end

    // Extend the selected lane according to the load type
    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h000000, byte_s};
            F3_HU:   data_o = {16'h0000, half_s};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Requester-side engine for the data-memory port. One CPU load/store is
// turned into one strobed access on data_mem; the memory's busy signal is
// followed and the result is returned as a one-cycle response pulse.
// Optional macro LSU_TIMEOUT_EN adds a WAIT-state watchdog that aborts
// with rsp_err after TIMEOUT_CYCLES busy cycles.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [3:0]        mem_sign_mask,
    input  logic [31:0]       mem_read_data,
    input  logic              mem_busy
);

    lsu_state_e state_q, state_d;

    // Latched request
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic              req_write_q, req_write_d;
    logic [2:0]        req_funct3_q, req_funct3_d;

    // Registered outputs
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_mask_q, mem_mask_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;

    logic [31:0]       align_data_s;
    logic              req_bad_s;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    // The timeout length is meaningless without the watchdog.
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    lsu_load_align u_load_align (
        .word_i    (mem_read_data),
        .addr_lo_i (req_addr_q[1:0]),
        .funct3_i  (req_funct3_q),
        .data_o    (align_data_s)
    );

    assign req_bad_s = ~funct3_is_legal(req_funct3, req_write)
                     | funct3_is_misaligned(req_funct3, req_addr[1:0]);

    // Next-state logic, request latching and response capture
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_write_d  = req_write_q;
        req_funct3_d = req_funct3_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
`ifdef LSU_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_addr_d   = req_addr;
                    req_wdata_d  = req_wdata;
                    req_write_d  = req_write;
                    req_funct3_d = req_funct3;
                    if (req_bad_s) begin
                        // Rejected without touching memory
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                wait_cnt_d = {CNT_W{1'b0}};
`endif
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b0;
                    if (req_write_q) begin
                        rsp_rdata_d = 32'h0000_0000;
                    end else begin
                        rsp_rdata_d = align_data_s;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next values, derived from the upcoming state
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
            memread_d   = ~req_write_d;
            memwrite_d  = req_write_d;
            mem_addr_d  = req_addr_d;
            mem_wdata_d = req_wdata_d;
            mem_mask_d  = funct3_to_sign_mask(req_funct3_d, req_write_d);
        end else begin
            // Strobes last only the ISSUE cycle; address/data/mask hold
            memread_d   = 1'b0;
            memwrite_d  = 1'b0;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
            mem_mask_d  = mem_mask_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, watchdog counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_q   <= {ADDR_W{1'b0}};
            req_wdata_q  <= 32'h0000_0000;
            req_write_q  <= 1'b0;
            req_funct3_q <= 3'b000;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            rsp_err_q    <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= 32'h0000_0000;
            mem_mask_q   <= 4'b0000;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_write_q  <= req_write_d;
            req_funct3_q <= req_funct3_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    // Strobes and the response pulse are cut immediately by reset so an
    // aborted access never shows a strobe or completion in the reset cycle.
    assign mem_memread    = memread_q & ~reset;
    assign mem_memwrite   = memwrite_q & ~reset;
    assign rsp_valid      = rsp_valid_q & ~reset;
    assign req_ready      = req_ready_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_sign_mask  = mem_mask_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus random
// loads/stores compared against a transaction-level reference model.
module tb_lsu_mem_initiator;

    localparam int ADDR_W = 32;
`ifdef LSU_TIMEOUT_EN
    localparam int TB_TO = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic              mem_memwrite;
    logic              mem_memread;
    logic [3:0]        mem_sign_mask;
    logic [31:0]       mem_read_data;
    logic              mem_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_busy       (mem_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: legality, alignment and the extended load value.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, output bit ok, output logic [31:0] data,
                         output logic [3:0] mask);
        int unsigned nbytes;
        logic [31:0] v;
        logic [31:0] msk;
        bit          legal_code;
        nbytes = 1 << f3[1:0];
        if (w) legal_code = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else   legal_code = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        ok   = legal_code && ((addr % nbytes) == 0);
        mask = {(!w && f3 < 3'd3), 3'(nbytes)};
        v    = word >> (8 * (addr % 4));
        if (nbytes < 4) begin
            msk = (32'h1 << (8 * nbytes)) - 32'h1;
            v   = v & msk;
            if (!f3[2] && v[8 * nbytes - 1]) v = v | ~msk;
        end
        data = (w || !ok) ? 32'h0 : v;
    endtask

    // One transaction; entered and left at a negedge with the DUT idle.
    // k = number of WAIT cycles with mem_busy held high.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input int k, input bit hold);
        bit          ok;
        bit          tmo;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
        logic        exp_err;
        int          lat;
        model(w, f3, addr, word, ok, exp_data, exp_mask);
        tmo     = ok && TO_EN && (k >= TB_TO);
        exp_err = !ok || tmo;
        if (tmo) exp_data = 32'h0;
        lat = !ok ? 1 : (tmo ? 2 + TB_TO : 3 + k);

        check_eq("ready_idle", 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_write     = w;
        req_funct3    = f3;
        req_addr      = addr;
        req_wdata     = wdata;
        mem_read_data = word;
        mem_busy      = 1'($urandom);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) begin
                req_valid  = 1'b0;
                req_write  = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            check_eq("rsp_valid", 32'(rsp_valid), 32'(c == lat));
            check_eq("req_ready_busy", 32'(req_ready), 32'd0);
            check_eq("memread", 32'(mem_memread), 32'(ok && !w && c == 1));
            check_eq("memwrite", 32'(mem_memwrite), 32'(ok && w && c == 1));
            if (ok && c < lat) begin
                check_eq("mem_addr", mem_addr, addr);
                check_eq("mem_sign_mask", 32'(mem_sign_mask), 32'(exp_mask));
                check_eq("mem_write_data", mem_write_data, wdata);
            end
            if (c == lat) begin
                check_eq("rsp_rdata", rsp_rdata, exp_data);
                check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
                req_valid = 1'b0;
                mem_busy  = 1'($urandom);
            end else begin
                mem_busy = (ok && c >= 2 && c <= 1 + k) ? 1'b1 : 1'b0;
            end
        end
        @(negedge clk);
        check_eq("ready_after", 32'(req_ready), 32'd1);
        check_eq("rsp_valid_after", 32'(rsp_valid), 32'd0);
        check_eq("rsp_rdata_hold", rsp_rdata, exp_data);
        check_eq("rsp_err_hold", 32'(rsp_err), 32'(exp_err));
    endtask

    // Start a word load and assert reset in cycle at_c (1 = ISSUE, 2+ = WAIT).
    task automatic reset_mid(input int at_c);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0300;
        req_wdata  = 32'h0;
        mem_busy   = 1'b0;
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c == 1) check_eq("rst_issue_strobe", 32'(mem_memread), 32'd1);
            mem_busy = (c >= 2) ? 1'b1 : 1'b0;
        end
        reset = 1'b1;
        #1;
        check_eq("rst_strobe_drop", 32'(mem_memread), 32'd0);
        check_eq("rst_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        mem_busy = 1'b0;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rst_quiet_valid", 32'(rsp_valid), 32'd0);
            check_eq("rst_quiet_read", 32'(mem_memread), 32'd0);
            check_eq("rst_quiet_ready", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mem_read_data = 32'h0;
        mem_busy      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_ready", 32'(req_ready), 32'd1);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("reset_mem_addr", mem_addr, 32'd0);
        check_eq("reset_mem_wdata", mem_write_data, 32'd0);
        check_eq("reset_mem_mask", 32'(mem_sign_mask), 32'd0);
        check_eq("reset_memread", 32'(mem_memread), 32'd0);
        check_eq("reset_memwrite", 32'(mem_memwrite), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, 1'b1);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_1234, 2, 1'b0);
        run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_0200, 32'h0000_ABCD, 32'h1111_2222, 5, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1234_5678, 0, 1'b0);
        run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 1'b1);
        run_txn(1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 32'h0, 0, 1'b0);
        run_txn(1'b0, 3'b111, 32'h0000_0104, 32'h0, 32'h0, 0, 1'b0);

        // Reset during ISSUE and during WAIT, then a normal load
        reset_mid(1);
        reset_mid(3);
        run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

        // Busy around the watchdog boundary and a very long stall
        run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, TB_TO - 1, 1'b0);
        run_txn(1'b1, 3'b010, 32'h0000_0504, 32'h7777_8888, 32'h0, TB_TO, 1'b0);
        run_txn(1'b0, 3'b001, 32'h0000_0506, 32'h0, 32'hFEDC_BA98, 1000, 1'b1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            run_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 6)),
                    1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
